pkt_chain_reader: RTL and testbench

- Packet-buffer read side, paired with the block free list.
- Accepts a packet descriptor (head block index, length in words) and walks the packet's linked chain of blocks in buffer memory.
- Streams the words out over a valid/ready interface.
- Returns each block to the free list with a one-cycle free pulse once that block's last needed word has been read back.

---
 rtl/pkt_chain_reader.sv | 169 ++++++++++++++++
 tb/tb_pkt_chain_reader.sv | 362 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pkt_chain_reader.sv
// Packet-buffer read side: walks a packet's linked block chain, streams its words out through a
// 2-entry FIFO and hands each block back to the free list once its last needed word is read.
module pkt_chain_reader #(
  parameter int unsigned ADDR_W          = 8,
  parameter int unsigned WORDS_PER_BLOCK = 4,
  parameter int unsigned DATA_W          = 64,
  parameter int unsigned LEN_W           = 16
) (
  input  logic                                        clk,
  input  logic                                        rst_n,
  input  logic                                        start_valid_i,
  output logic                                        start_ready_o,
  input  logic [ADDR_W-1:0]                           start_head_i,
  input  logic [LEN_W-1:0]                            start_len_i,
  output logic                                        mem_rd_en_o,
  output logic [ADDR_W+$clog2(WORDS_PER_BLOCK)-1:0]   mem_rd_addr_o,
  input  logic [DATA_W-1:0]                           mem_rd_data_i,
  output logic                                        nxt_rd_en_o,
  output logic [ADDR_W-1:0]                           nxt_rd_idx_o,
  input  logic [ADDR_W-1:0]                           nxt_rd_data_i,
  output logic                                        out_valid_o,
  input  logic                                        out_ready_i,
  output logic [DATA_W-1:0]                           out_data_o,
  output logic                                        out_last_o,
  output logic                                        free_req_o,
  output logic [ADDR_W-1:0]                           free_block_idx_o
);

  localparam int unsigned OFF_W = $clog2(WORDS_PER_BLOCK);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StRead  = 2'd1;
  localparam logic [1:0] StFlush = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] cur_blk_q, cur_blk_d;
  logic [OFF_W-1:0]  offset_q, offset_d;
  logic [LEN_W-1:0]  remaining_q, remaining_d;

  logic [ADDR_W-1:0] nxt_blk_q;
  logic              nxt_cap_q;

  // Tag of the read issued last cycle, whose data is on mem_rd_data_i now.
  logic              rd_vld_q;
  logic              rd_last_q;
  logic              rd_free_q;
  logic [ADDR_W-1:0] rd_blk_q;

  logic              free_q;
  logic [ADDR_W-1:0] free_idx_q;

  logic [DATA_W-1:0] fifo_data_q [2];
  logic [1:0]        fifo_last_q;
  logic              wr_ptr_q, rd_ptr_q;
  logic [1:0]        fifo_cnt_q;

  logic              start_fire, zero_len, pop, issue, last_word, wrap, free_fire;
  logic [2:0]        occ;
  logic [ADDR_W-1:0] nxt_val;

  always_comb begin
    start_ready_o    = (state_q == StIdle) && !free_q;
    start_fire       = start_valid_i && start_ready_o;
    zero_len         = start_fire && (start_len_i == '0);

    out_valid_o      = (fifo_cnt_q != 2'd0);
    out_data_o       = fifo_data_q[rd_ptr_q];
    out_last_o       = out_valid_o && fifo_last_q[rd_ptr_q];
    pop              = out_valid_o && out_ready_i;

    // Slots a new read would compete for, counting this cycle's pop as already freed.
    occ              = 3'(fifo_cnt_q) + 3'(rd_vld_q) - 3'(pop);
    issue            = (state_q == StRead) && (occ < 3'd2);
    last_word        = (remaining_q == LEN_W'(1));
    wrap             = (offset_q == OFF_W'(WORDS_PER_BLOCK - 1));
    // With two words per block the successor lands in the same cycle as the wrap.
    nxt_val          = nxt_cap_q ? nxt_rd_data_i : nxt_blk_q;

    mem_rd_en_o      = issue;
    mem_rd_addr_o    = {cur_blk_q, offset_q};
    nxt_rd_en_o      = issue && (offset_q == '0) &&
                       (remaining_q > LEN_W'(WORDS_PER_BLOCK));
    nxt_rd_idx_o     = cur_blk_q;

    free_fire        = (rd_vld_q && rd_free_q) || zero_len;
    free_req_o       = free_q;
    free_block_idx_o = free_idx_q;
  end

  always_comb begin
    state_d     = state_q;
    cur_blk_d   = cur_blk_q;
    offset_d    = offset_q;
    remaining_d = remaining_q;
    unique case (state_q)
      StIdle: begin
        if (start_fire) begin
          cur_blk_d   = start_head_i;
          remaining_d = start_len_i;
          offset_d    = '0;
          if (start_len_i != '0) state_d = StRead;
        end
      end
      StRead: begin
        if (issue) begin
          offset_d    = offset_q + OFF_W'(1);
          remaining_d = remaining_q - LEN_W'(1);
          if (wrap) cur_blk_d = nxt_val;
          if (last_word) state_d = StFlush;
        end
      end
      StFlush: begin
        // The final block's free fires exactly as the last read retires.
        if (!rd_vld_q && free_q) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= StIdle;
      cur_blk_q      <= '0;
      offset_q       <= '0;
      remaining_q    <= '0;
      nxt_blk_q      <= '0;
      nxt_cap_q      <= 1'b0;
      rd_vld_q       <= 1'b0;
      rd_last_q      <= 1'b0;
      rd_free_q      <= 1'b0;
      rd_blk_q       <= '0;
      free_q         <= 1'b0;
      free_idx_q     <= '0;
      fifo_data_q[0] <= '0;
      fifo_data_q[1] <= '0;
      fifo_last_q    <= '0;
      wr_ptr_q       <= 1'b0;
      rd_ptr_q       <= 1'b0;
      fifo_cnt_q     <= '0;
    end else begin
      state_q     <= state_d;
      cur_blk_q   <= cur_blk_d;
      offset_q    <= offset_d;
      remaining_q <= remaining_d;

      nxt_cap_q <= nxt_rd_en_o;
      if (nxt_cap_q) nxt_blk_q <= nxt_rd_data_i;

      rd_vld_q <= issue;
      if (issue) begin
        rd_last_q <= last_word;
        rd_free_q <= wrap || last_word;
        rd_blk_q  <= cur_blk_q;
      end

      free_q <= free_fire;
      if (free_fire) free_idx_q <= zero_len ? start_head_i : rd_blk_q;

      if (rd_vld_q) begin
        fifo_data_q[wr_ptr_q] <= mem_rd_data_i;
        fifo_last_q[wr_ptr_q] <= rd_last_q;
        wr_ptr_q              <= !wr_ptr_q;
      end
      if (pop) rd_ptr_q <= !rd_ptr_q;
      fifo_cnt_q <= fifo_cnt_q + 2'(rd_vld_q) - 2'(pop);
    end
  end

endmodule

// File: tb/tb_pkt_chain_reader.sv
// Directed bench for pkt_chain_reader with a 1-cycle buffer memory and next-pointer table model.
module tb_pkt_chain_reader;

  localparam int ADDR_W = 8;
  localparam int DATA_W = 64;
  localparam int LEN_W  = 16;
  localparam int MA_W   = 10;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start_valid_i = 1'b0;
  logic              start_ready_o;
  logic [ADDR_W-1:0] start_head_i = '0;
  logic [LEN_W-1:0]  start_len_i = '0;
  logic              mem_rd_en_o;
  logic [MA_W-1:0]   mem_rd_addr_o;
  logic [DATA_W-1:0] mem_rd_data_i = '0;
  logic              nxt_rd_en_o;
  logic [ADDR_W-1:0] nxt_rd_idx_o;
  logic [ADDR_W-1:0] nxt_rd_data_i = '0;
  logic              out_valid_o;
  logic              out_ready_i = 1'b1;
  logic [DATA_W-1:0] out_data_o;
  logic              out_last_o;
  logic              free_req_o;
  logic [ADDR_W-1:0] free_block_idx_o;

  pkt_chain_reader dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .start_valid_i    (start_valid_i),
    .start_ready_o    (start_ready_o),
    .start_head_i     (start_head_i),
    .start_len_i      (start_len_i),
    .mem_rd_en_o      (mem_rd_en_o),
    .mem_rd_addr_o    (mem_rd_addr_o),
    .mem_rd_data_i    (mem_rd_data_i),
    .nxt_rd_en_o      (nxt_rd_en_o),
    .nxt_rd_idx_o     (nxt_rd_idx_o),
    .nxt_rd_data_i    (nxt_rd_data_i),
    .out_valid_o      (out_valid_o),
    .out_ready_i      (out_ready_i),
    .out_data_o       (out_data_o),
    .out_last_o       (out_last_o),
    .free_req_o       (free_req_o),
    .free_block_idx_o (free_block_idx_o)
  );

  always #5 clk = ~clk;

  logic [ADDR_W-1:0] nxt_tbl [256];

  function automatic logic [DATA_W-1:0] word_of(input logic [MA_W-1:0] a);
    return 64'hBEEF_0000_0000_0000 | {54'b0, a};
  endfunction

  always @(posedge clk) begin
    mem_rd_data_i <= word_of(mem_rd_addr_o);
    nxt_rd_data_i <= nxt_tbl[nxt_rd_idx_o];
  end

  int                checks = 0;
  int                fails = 0;
  int                cyc = 0;
  logic [MA_W-1:0]   rd_log [$];
  int                rd_cyc [$];
  logic [ADDR_W-1:0] nxt_log [$];
  logic [ADDR_W-1:0] free_log [$];
  int                free_cyc [$];
  int                acc_cyc [$];
  logic [DATA_W-1:0] out_dat [$];
  logic              out_lst [$];
  int                max_out = 0;
  int                ready_low = 0;
  int                outst;

  always @(negedge clk) begin
    cyc++;
    if (rst_n) begin
      if (mem_rd_en_o) begin
        rd_log.push_back(mem_rd_addr_o);
        rd_cyc.push_back(cyc);
      end
      if (nxt_rd_en_o) nxt_log.push_back(nxt_rd_idx_o);
      if (out_valid_o && out_ready_i) begin
        out_dat.push_back(out_data_o);
        out_lst.push_back(out_last_o);
      end
      if (free_req_o) begin
        free_log.push_back(free_block_idx_o);
        free_cyc.push_back(cyc);
      end
      if (start_valid_i && start_ready_o) acc_cyc.push_back(cyc);
      if (!start_ready_o) ready_low++;
      outst = rd_log.size() - out_dat.size();
      if (outst > max_out) max_out = outst;
    end
  end

  task automatic clear_logs();
    rd_log.delete(); rd_cyc.delete(); nxt_log.delete(); free_log.delete();
    free_cyc.delete(); acc_cyc.delete(); out_dat.delete(); out_lst.delete();
    max_out = 0; ready_low = 0;
  endtask

  task automatic send_desc(input logic [ADDR_W-1:0] head, input logic [LEN_W-1:0] len);
    int k = 0;
    @(posedge clk); #1;
    start_valid_i = 1'b1; start_head_i = head; start_len_i = len;
    @(negedge clk);
    while (!start_ready_o && k < 50) begin @(negedge clk); k++; end
    @(posedge clk); #1;
    start_valid_i = 1'b0;
    checks++;
    if (k >= 50) begin fails++; $display("FAIL desc_accept: head %0d not accepted in 50 cycles", head); end
  endtask

  task automatic wait_outs(input int n);
    int k = 0;
    while (out_dat.size() < n && k < 300) begin @(negedge clk); k++; end
    repeat (6) @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({start_ready_o, mem_rd_en_o, nxt_rd_en_o, out_valid_o, out_last_o, free_req_o} !== 6'b100000) begin
      fails++;
      $display("FAIL reset_ctrl: got %b want 100000",
               {start_ready_o, mem_rd_en_o, nxt_rd_en_o, out_valid_o, out_last_o, free_req_o});
    end
    checks++;
    if (mem_rd_addr_o !== '0 || out_data_o !== '0 || free_block_idx_o !== '0 || nxt_rd_idx_o !== '0) begin
      fails++;
      $display("FAIL reset_data: addr %0h data %0h free_idx %0h nxt_idx %0h want all 0",
               mem_rd_addr_o, out_data_o, free_block_idx_o, nxt_rd_idx_o);
    end
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (start_ready_o !== 1'b1) begin fails++; $display("FAIL reset_ready: got %b want 1", start_ready_o); end
  endtask

  task automatic test_single_block();
    logic [MA_W-1:0] exp_a [$];
    for (int i = 0; i < 4; i++) exp_a.push_back({8'd5, 2'(i)});
    clear_logs();
    send_desc(8'd5, 16'd4);
    wait_outs(4);
    checks++;
    if (rd_log.size() != 4) begin fails++; $display("FAIL single_nreads: got %0d want 4", rd_log.size()); end
    for (int i = 0; i < 4 && i < rd_log.size(); i++) begin
      checks++;
      if (rd_log[i] !== exp_a[i]) begin fails++; $display("FAIL single_addr[%0d]: got %0h want %0h", i, rd_log[i], exp_a[i]); end
      if (i > 0) begin
        checks++;
        if (rd_cyc[i] != rd_cyc[0] + i) begin fails++; $display("FAIL single_consec[%0d]: cycle %0d want %0d", i, rd_cyc[i], rd_cyc[0] + i); end
      end
    end
    checks++;
    if (out_dat.size() != 4) begin fails++; $display("FAIL single_nout: got %0d want 4", out_dat.size()); end
    for (int i = 0; i < 4 && i < out_dat.size(); i++) begin
      checks++;
      if (out_dat[i] !== word_of(exp_a[i]) || out_lst[i] !== (i == 3)) begin
        fails++;
        $display("FAIL single_out[%0d]: got %0h/%b want %0h/%b", i, out_dat[i], out_lst[i], word_of(exp_a[i]), i == 3);
      end
    end
    checks++;
    if (free_log.size() != 1 || free_log[0] !== 8'd5) begin
      fails++; $display("FAIL single_free: got %0d pulses first %0d want 1 pulse idx 5", free_log.size(), free_log.size() > 0 ? free_log[0] : 0);
    end
    checks++;
    if (nxt_log.size() != 0) begin fails++; $display("FAIL single_nxt: got %0d nxt reads want 0", nxt_log.size()); end
    checks++;
    if (start_ready_o !== 1'b1) begin fails++; $display("FAIL single_ready: got %b want 1", start_ready_o); end
  endtask

  task automatic test_chain();
    logic [MA_W-1:0]   exp_a [$];
    logic [ADDR_W-1:0] exp_f [3];
    exp_f[0] = 8'd2; exp_f[1] = 8'd7; exp_f[2] = 8'd3;
    for (int i = 0; i < 4; i++) exp_a.push_back({8'd2, 2'(i)});
    for (int i = 0; i < 4; i++) exp_a.push_back({8'd7, 2'(i)});
    for (int i = 0; i < 2; i++) exp_a.push_back({8'd3, 2'(i)});
    clear_logs();
    send_desc(8'd2, 16'd10);
    wait_outs(10);
    checks++;
    if (rd_log.size() != 10) begin fails++; $display("FAIL chain_nreads: got %0d want 10", rd_log.size()); end
    for (int i = 0; i < 10 && i < rd_log.size(); i++) begin
      checks++;
      if (rd_log[i] !== exp_a[i]) begin fails++; $display("FAIL chain_addr[%0d]: got %0h want %0h", i, rd_log[i], exp_a[i]); end
    end
    checks++;
    if (out_dat.size() != 10) begin fails++; $display("FAIL chain_nout: got %0d want 10", out_dat.size()); end
    for (int i = 0; i < 10 && i < out_dat.size(); i++) begin
      checks++;
      if (out_dat[i] !== word_of(exp_a[i]) || out_lst[i] !== (i == 9)) begin
        fails++;
        $display("FAIL chain_out[%0d]: got %0h/%b want %0h/%b", i, out_dat[i], out_lst[i], word_of(exp_a[i]), i == 9);
      end
    end
    checks++;
    if (free_log.size() != 3) begin fails++; $display("FAIL chain_nfree: got %0d want 3", free_log.size()); end
    for (int i = 0; i < 3 && i < free_log.size(); i++) begin
      checks++;
      if (free_log[i] !== exp_f[i]) begin fails++; $display("FAIL chain_free[%0d]: got %0d want %0d", i, free_log[i], exp_f[i]); end
    end
    checks++;
    if (nxt_log.size() != 2 || nxt_log[0] !== 8'd2 || nxt_log[1] !== 8'd7) begin
      fails++; $display("FAIL chain_nxt: got %0d reads want 2 reads of blocks 2,7", nxt_log.size());
    end
  endtask

  task automatic test_stall();
    logic [MA_W-1:0]   exp_a [$];
    logic [DATA_W-1:0] held;
    int k = 0;
    int pops = 0;
    bit stable = 1'b1;
    for (int i = 0; i < 4; i++) exp_a.push_back({8'd1, 2'(i)});
    for (int i = 0; i < 2; i++) exp_a.push_back({8'd11, 2'(i)});
    clear_logs();
    send_desc(8'd1, 16'd6);
    while (pops < 2 && k < 50) begin
      @(negedge clk);
      if (out_valid_o && out_ready_i) pops++;
      k++;
    end
    @(posedge clk); #1 out_ready_i = 1'b0;
    @(negedge clk);
    held = out_data_o;
    if (!out_valid_o) stable = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (!out_valid_o || out_data_o !== held) stable = 1'b0;
    end
    @(posedge clk); #1 out_ready_i = 1'b1;
    checks++;
    if (!stable) begin fails++; $display("FAIL stall_hold: output changed or dropped valid while stalled (held %0h)", held); end
    wait_outs(6);
    checks++;
    if (max_out > 2) begin fails++; $display("FAIL stall_outstanding: got %0d want <= 2", max_out); end
    checks++;
    if (out_dat.size() != 6) begin fails++; $display("FAIL stall_nout: got %0d want 6", out_dat.size()); end
    for (int i = 0; i < 6 && i < out_dat.size(); i++) begin
      checks++;
      if (out_dat[i] !== word_of(exp_a[i]) || out_lst[i] !== (i == 5)) begin
        fails++;
        $display("FAIL stall_out[%0d]: got %0h/%b want %0h/%b", i, out_dat[i], out_lst[i], word_of(exp_a[i]), i == 5);
      end
    end
    checks++;
    if (free_log.size() != 2 || free_log[0] !== 8'd1 || free_log[1] !== 8'd11) begin
      fails++; $display("FAIL stall_free: got %0d pulses want 2 pulses idx 1,11", free_log.size());
    end
  endtask

  task automatic test_zero_len();
    clear_logs();
    send_desc(8'd9, 16'd0);
    repeat (8) @(negedge clk);
    checks++;
    if (rd_log.size() != 0 || out_dat.size() != 0 || nxt_log.size() != 0) begin
      fails++; $display("FAIL zero_activity: reads %0d outs %0d nxt %0d want 0 0 0", rd_log.size(), out_dat.size(), nxt_log.size());
    end
    checks++;
    if (free_log.size() != 1 || free_log[0] !== 8'd9) begin
      fails++; $display("FAIL zero_free: got %0d pulses want 1 pulse idx 9", free_log.size());
    end
    checks++;
    if (free_cyc.size() != 1 || acc_cyc.size() != 1 || free_cyc[0] != acc_cyc[0] + 1) begin
      fails++; $display("FAIL zero_free_time: free not exactly one cycle after accept");
    end
    checks++;
    if (ready_low != 1) begin fails++; $display("FAIL zero_ready_low: got %0d cycles want 1", ready_low); end
  endtask

  task automatic test_back_to_back();
    clear_logs();
    send_desc(8'd4, 16'd1);
    send_desc(8'd6, 16'd1);
    wait_outs(2);
    checks++;
    if (rd_log.size() != 2 || rd_log[0] !== {8'd4, 2'd0} || rd_log[1] !== {8'd6, 2'd0}) begin
      fails++; $display("FAIL b2b_reads: got %0d reads want addr 10, 18 (hex)", rd_log.size());
    end
    checks++;
    if (out_dat.size() != 2) begin fails++; $display("FAIL b2b_nout: got %0d want 2", out_dat.size()); end
    for (int i = 0; i < 2 && i < out_dat.size(); i++) begin
      checks++;
      if (out_dat[i] !== word_of({i == 0 ? 8'd4 : 8'd6, 2'd0}) || out_lst[i] !== 1'b1) begin
        fails++; $display("FAIL b2b_out[%0d]: got %0h/%b want %0h/1", i, out_dat[i], out_lst[i], word_of({i == 0 ? 8'd4 : 8'd6, 2'd0}));
      end
    end
    checks++;
    if (free_log.size() != 2 || free_log[0] !== 8'd4 || free_log[1] !== 8'd6) begin
      fails++; $display("FAIL b2b_free: got %0d pulses want idx 4 then 6", free_log.size());
    end
    checks++;
    if (acc_cyc.size() != 2 || free_cyc.size() < 1 || acc_cyc[1] <= free_cyc[0]) begin
      fails++; $display("FAIL b2b_order: second descriptor accepted before first packet's free");
    end
  endtask

  task automatic test_reset_mid();
    int k = 0;
    int n = 0;
    clear_logs();
    send_desc(8'd12, 16'd8);
    while (n < 3 && k < 50) begin
      @(negedge clk);
      if (mem_rd_en_o) n++;
      k++;
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({mem_rd_en_o, nxt_rd_en_o, out_valid_o, out_last_o, free_req_o} !== 5'b0 ||
        mem_rd_addr_o !== '0 || out_data_o !== '0 || free_block_idx_o !== '0) begin
      fails++;
      $display("FAIL rstmid_outputs: ctrl %b addr %0h data %0h want all 0",
               {mem_rd_en_o, nxt_rd_en_o, out_valid_o, out_last_o, free_req_o}, mem_rd_addr_o, out_data_o);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    clear_logs();
    repeat (10) @(negedge clk);
    checks++;
    if (start_ready_o !== 1'b1) begin fails++; $display("FAIL rstmid_ready: got %b want 1", start_ready_o); end
    checks++;
    if (free_log.size() != 0 || rd_log.size() != 0 || out_dat.size() != 0) begin
      fails++; $display("FAIL rstmid_quiet: frees %0d reads %0d outs %0d want 0 0 0", free_log.size(), rd_log.size(), out_dat.size());
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 256; i++) nxt_tbl[i] = '0;
    nxt_tbl[2]  = 8'd7;
    nxt_tbl[7]  = 8'd3;
    nxt_tbl[1]  = 8'd11;
    nxt_tbl[12] = 8'd13;
    test_reset();
    test_single_block();
    test_chain();
    test_stall();
    test_zero_len();
    test_back_to_back();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
